// File: rtl/orb_write_arbiter.sv
// Orbit RAM write arbiter. Three requesters (digital, analog, service)
// share a single write port into a double-banked orbit RAM. Each write takes
// four cycles: IDLE decision, SETUP (capture word/address), STROBE (wren),
// RELEASE (ack). The readout side signals completion of the read bank with
// frameDone; the bank swap is deferred to IDLE so a write never straddles
// banks.
module orb_write_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [3*DATA_W-1:0]   reqWord,
  input  logic [3*ADDR_W-1:0]   reqAddr,
  output logic [2:0]            ack,
  input  logic                  frameDone,
  output logic                  orbSwitch,
  output logic [DATA_W-1:0]     orbWord,
  output logic [ADDR_W:0]       orbAddr,
  output logic                  orbWren,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t     state;
  logic [1:0] sel;
  logic [1:0] lastGnt;
  logic       swapPending;
  logic       pickValid;
  logic [1:0] pickSel;
  logic       swapNow;

  // Round-robin pick: first set request searching upward from lastGnt+1 mod 3.
  // Returns {valid, index}; idle requesters cost nothing.
  function automatic logic [2:0] rrPick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rrPick = 3'b000;
    // Walk the search order backwards so the earliest candidate wins.
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (r[idx]) rrPick = {1'b1, idx};
    end
  endfunction

  // Grant candidate for the current IDLE cycle.
  always_comb begin
    {pickValid, pickSel} = rrPick(req, lastGnt);
  end

  assign swapNow = (state == IDLE) && swapPending;
  assign busy    = (state != IDLE);

  // Write sequencer, bank swap and overrun tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sel         <= 2'd0;
      lastGnt     <= 2'd2;
      orbWren     <= 1'b0;
      orbWord     <= '0;
      orbAddr     <= '0;
      ack         <= 3'b000;
      orbSwitch   <= 1'b0;
      swapPending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ack <= 3'b000;
      case (state)
        IDLE: begin
          // A pending swap pre-empts any grant this cycle.
          if (swapPending) begin
            orbSwitch <= ~orbSwitch;
          end else if (pickValid) begin
            sel   <= pickSel;
            state <= SETUP;
          end
        end
        SETUP: begin
          // Requester data is captured here only; later changes are ignored.
          orbWord <= reqWord[int'(sel)*DATA_W +: DATA_W];
          orbAddr <= {orbSwitch, reqAddr[int'(sel)*ADDR_W +: ADDR_W]};
          orbWren <= 1'b1;
          state   <= STROBE;
        end
        STROBE: begin
          orbWren  <= 1'b0;
          ack[sel] <= 1'b1;
          state    <= RELEASE;
        end
        RELEASE: begin
          lastGnt <= sel;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A frameDone coinciding with a swap arms the following swap instead.
      if (swapNow) begin
        swapPending <= frameDone;
      end else if (frameDone) begin
        if (swapPending) overrun <= 1'b1;
        else             swapPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_orb_write_arbiter.sv
// Directed bench for orb_write_arbiter: single write, round-robin, bank swap,
// overrun, reset mid-write and request drop after capture.
module tb_orb_write_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;

  logic                clk;
  logic                reset;
  logic [2:0]          req;
  logic [3*DATA_W-1:0] reqWord;
  logic [3*ADDR_W-1:0] reqAddr;
  logic [2:0]          ack;
  logic                frameDone;
  logic                orbSwitch;
  logic [DATA_W-1:0]   orbWord;
  logic [ADDR_W:0]     orbAddr;
  logic                orbWren;
  logic                overrun;
  logic                busy;

  int total = 0;
  int bad   = 0;

  orb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req(req), .reqWord(reqWord), .reqAddr(reqAddr),
    .ack(ack), .frameDone(frameDone), .orbSwitch(orbSwitch), .orbWord(orbWord),
    .orbAddr(orbAddr), .orbWren(orbWren), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0; req = 3'b000; frameDone = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000; frameDone = 1'b0; reqWord = '0; reqAddr = '0;
    #2 reset = 1'b0;
    #3;
    total++; if (orbWren !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", orbWren); end
    total++; if (orbWord !== 12'h000) begin bad++; $display("FAIL rst_word got=%h exp=000", orbWord); end
    total++; if (orbAddr !== 11'h000) begin bad++; $display("FAIL rst_addr got=%h exp=000", orbAddr); end
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL rst_ack got=%b exp=000", ack); end
    total++; if ({orbSwitch, overrun, busy} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {orbSwitch, overrun, busy}); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_single();
    req = 3'b001; reqWord[0 +: 12] = 12'h5A5; reqAddr[0 +: 10] = 10'h003;
    tick();
    total++; if ({busy, orbWren} !== 2'b10) begin bad++; $display("FAIL single_setup got=%b exp=10", {busy, orbWren}); end
    tick();
    total++; if (orbWren !== 1'b1) begin bad++; $display("FAIL single_wren got=%b exp=1", orbWren); end
    total++; if (orbAddr !== 11'h003) begin bad++; $display("FAIL single_addr got=%h exp=003", orbAddr); end
    total++; if (orbWord !== 12'h5A5) begin bad++; $display("FAIL single_word got=%h exp=5a5", orbWord); end
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL single_ack_early got=%b exp=000", ack); end
    tick();
    total++; if ({orbWren, ack} !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b exp=0001", {orbWren, ack}); end
    req = 3'b000;
    tick();
    total++; if ({busy, ack} !== 4'b0000) begin bad++; $display("FAIL single_done got=%b exp=0000", {busy, ack}); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  expAck;
    logic [11:0] expWord;
    doReset();
    reqWord = {12'h333, 12'h222, 12'h111};
    req = 3'b111;
    for (int c = 1; c <= 24; c++) begin
      tick();
      expAck = (c % 4 == 3) ? (3'b001 << ((c / 4) % 3)) : 3'b000;
      total++; if (ack !== expAck) begin bad++; $display("FAIL rr_ack c=%0d got=%b exp=%b", c, ack, expAck); end
      if (c % 4 == 2) begin
        expWord = 12'h111 * 12'(((c / 4) % 3) + 1);
        total++; if ({orbWren, orbWord} !== {1'b1, expWord}) begin bad++; $display("FAIL rr_word c=%0d got=%b/%h exp=1/%h", c, orbWren, orbWord, expWord); end
      end
    end
    req = 3'b000;
    repeat (4) tick();
  endtask

  task automatic test_swap();
    doReset();
    req = 3'b010; reqWord[12 +: 12] = 12'hABC; reqAddr[10 +: 10] = 10'h055;
    tick();
    tick();
    total++; if ({orbWren, orbAddr} !== {1'b1, 11'h055}) begin bad++; $display("FAIL swap_old_bank got=%b/%h exp=1/055", orbWren, orbAddr); end
    frameDone = 1'b1;
    tick();
    frameDone = 1'b0;
    total++; if ({ack, orbSwitch} !== 4'b0100) begin bad++; $display("FAIL swap_ack got=%b exp=0100", {ack, orbSwitch}); end
    req = 3'b001; reqWord[0 +: 12] = 12'h123; reqAddr[0 +: 10] = 10'h00A;
    tick();
    total++; if ({busy, orbSwitch} !== 2'b00) begin bad++; $display("FAIL swap_idle got=%b exp=00", {busy, orbSwitch}); end
    tick();
    total++; if ({busy, orbSwitch} !== 2'b01) begin bad++; $display("FAIL swap_exec got=%b exp=01", {busy, orbSwitch}); end
    tick();
    tick();
    total++; if ({orbWren, orbAddr} !== {1'b1, 11'h40A}) begin bad++; $display("FAIL swap_new_bank got=%b/%h exp=1/40a", orbWren, orbAddr); end
    tick();
    total++; if ({ack, overrun} !== 4'b0010) begin bad++; $display("FAIL swap_ack2 got=%b exp=0010", {ack, overrun}); end
    req = 3'b000;
    repeat (2) tick();
  endtask

  task automatic test_overrun();
    doReset();
    req = 3'b111; reqAddr = {10'h300, 10'h200, 10'h100};
    tick();
    frameDone = 1'b1;
    tick();
    frameDone = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b exp=0", overrun); end
    tick();
    frameDone = 1'b1;
    tick();
    frameDone = 1'b0;
    total++; if ({overrun, orbSwitch} !== 2'b10) begin bad++; $display("FAIL ovr_second got=%b exp=10", {overrun, orbSwitch}); end
    tick();
    total++; if ({busy, orbSwitch} !== 2'b01) begin bad++; $display("FAIL ovr_swap got=%b exp=01", {busy, orbSwitch}); end
    tick();
    tick();
    total++; if (orbAddr !== 11'h600) begin bad++; $display("FAIL ovr_addr got=%h exp=600", orbAddr); end
    tick();
    total++; if (ack !== 3'b010) begin bad++; $display("FAIL ovr_ack got=%b exp=010", ack); end
    repeat (4) tick();
    total++; if ({overrun, orbSwitch} !== 2'b11) begin bad++; $display("FAIL ovr_sticky got=%b exp=11", {overrun, orbSwitch}); end
    req = 3'b000;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    req = 3'b001;
    tick();
    tick();
    total++; if (orbWren !== 1'b1) begin bad++; $display("FAIL rmid_strobe got=%b exp=1", orbWren); end
    #2 reset = 1'b0;
    #1;
    total++; if ({orbWren, ack, orbSwitch, overrun, busy} !== 7'b0) begin bad++; $display("FAIL rmid_async got=%b exp=0000000", {orbWren, ack, orbSwitch, overrun, busy}); end
    req = 3'b100; reqWord[24 +: 12] = 12'h777; reqAddr[20 +: 10] = 10'h011;
    tick();
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL rmid_noack got=%b exp=000", ack); end
    reset = 1'b1;
    tick();
    tick();
    total++; if ({orbWren, orbAddr, orbWord} !== {1'b1, 11'h011, 12'h777}) begin bad++; $display("FAIL rmid_req2 got=%b/%h/%h exp=1/011/777", orbWren, orbAddr, orbWord); end
    tick();
    total++; if (ack !== 3'b100) begin bad++; $display("FAIL rmid_ack got=%b exp=100", ack); end
    req = 3'b000;
    repeat (2) tick();
  endtask

  task automatic test_drop();
    doReset();
    req = 3'b010; reqWord[12 +: 12] = 12'h3C3; reqAddr[10 +: 10] = 10'h021;
    tick();
    tick();
    req = 3'b000; reqWord[12 +: 12] = 12'hFFF;
    total++; if ({orbWren, orbWord} !== {1'b1, 12'h3C3}) begin bad++; $display("FAIL drop_word got=%b/%h exp=1/3c3", orbWren, orbWord); end
    tick();
    total++; if ({ack, orbWord} !== {3'b010, 12'h3C3}) begin bad++; $display("FAIL drop_ack got=%b/%h exp=010/3c3", ack, orbWord); end
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_swap();
    test_overrun();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/orb_write_arbiter.md
ORB_WRITE_ARBITER -- requirements
Module: orb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, per-bank RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 12, orbit word width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  3  per-requester write request, level, held until ack (bit0 digital, bit1 analog, bit2 service).
REQ-006 SHALL have port reqWord  input  3*DATA_W  requester words, requester i at [i*DATA_W +: DATA_W].
REQ-007 SHALL have port reqAddr  input  3*ADDR_W  requester addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port ack  output  3  one-cycle pulse, write of requester i completed.
REQ-009 SHALL have port frameDone  input  1  one-cycle pulse from readout side: read bank finished.
REQ-010 SHALL have port orbSwitch  output  1  current write-bank select; readers use ~orbSwitch.
REQ-011 SHALL have port orbWord  output  DATA_W  RAM write data.
REQ-012 SHALL have port orbAddr  output  ADDR_W+1  RAM write address {orbSwitch, addr}.
REQ-013 SHALL have port orbWren  output  1  RAM write enable.
REQ-014 SHALL have port overrun  output  1  sticky: frameDone arrived while a swap was still pending.
REQ-015 SHALL have port busy  output  1  high in any FSM state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> STROBE -> RELEASE -> IDLE, one cycle per non-IDLE state.
REQ-017 IDLE: if any req bit set and no swap pending, SHALL select one requester by round-robin and enter SETUP next cycle.
REQ-018 Round-robin SHALL search from (last granted + 1) mod 3 upward; after reset last granted = 2, so requester 0 wins first.
REQ-019 SETUP: SHALL register orbWord = reqWord[sel], orbAddr = {orbSwitch, reqAddr[sel]}, orbWren = 0.
REQ-020 STROBE: SHALL drive orbWren = 1; orbWord/orbAddr stable.
REQ-021 RELEASE: SHALL drive orbWren = 0 and ack[sel] = 1 for exactly this cycle; update last granted = sel.
REQ-022 Grant-to-ack latency SHALL be 3 cycles after IDLE decision; maximum throughput one write per 4 cycles.
REQ-023 Word/address SHALL be sampled only in SETUP; requester changes after SETUP SHALL not affect the write.
REQ-024 Requester dropping req before ack SHALL still complete the in-flight write (no abort).
REQ-025 frameDone SHALL set swapPending; if swapPending already set, SHALL set overrun instead (pending stays 1).
REQ-026 Swap SHALL execute only in IDLE: orbSwitch toggles, swapPending clears, no grant that cycle.
REQ-027 Swap SHALL take priority over pending requests in IDLE; a write in progress SHALL finish in the old bank first.
REQ-028 frameDone in the same cycle as a swap execution SHALL set swapPending for the next swap, no overrun.
REQ-029 orbAddr SHALL never change bank bit within a write (SETUP..RELEASE).
REQ-030 At most one ack bit SHALL be high in any cycle; orbWren high at most 1 cycle in 4.
REQ-031 overrun SHALL clear only by reset.
REQ-032 Unused req bits at 0 SHALL be skipped without costing cycles.

Reset
REQ-033 On reset low, SHALL asynchronously force: state IDLE, orbWren 0, orbWord 0, orbAddr 0, ack 0, orbSwitch 0, swapPending 0, overrun 0, busy 0, last granted 2.
REQ-034 Reset mid-write SHALL abort with no ack; first post-reset cycle SHALL be IDLE.

Verification
REQ-035 req=3'b001, word 12'h5A5, addr 10'h003 -> orbWren high exactly 1 cycle with orbAddr 11'h003, orbWord 12'h5A5; ack=3'b001 next cycle.
REQ-036 req=3'b111 held continuously -> ack order 0,1,2,0,1,2, one ack per 4 cycles.
REQ-037 frameDone during STROBE of requester 1 -> that write uses bank 0; orbSwitch=1 in following IDLE; next write orbAddr[10]=1.
REQ-038 two frameDone pulses while FSM busy with continuous requests -> overrun=1 after second pulse, single orbSwitch toggle.
REQ-039 reset asserted during STROBE -> orbWren 0 immediately, no ack, orbSwitch 0, overrun 0; req=3'b100 afterwards -> requester 2 served first (only requester).
REQ-040 req=3'b010 dropped right after SETUP with reqWord changed -> write uses word sampled in SETUP, ack[1] still pulses.
